// File: rtl/div_approx_pkg.sv
// Shared types and helpers for the sequential approximate array divider.
package div_approx_pkg;

   // Controller states of the iterative divider
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Kind of subtractor cell used at one (row, column) position
   typedef enum logic {
      CELL_EXACT  = 1'b0,
      CELL_APPROX = 1'b1
   } cell_kind_e;

   // Low-order quotient rows and low-order columns use the approximate cell
   function automatic cell_kind_e cell_is_approx(input int k, input int c,
                                                 input int approx_rows,
                                                 input int approx_cols);
      return ((k < approx_rows) && (c < approx_cols)) ? CELL_APPROX : CELL_EXACT;
   endfunction

endpackage

// File: rtl/div_sub_cell.sv
// One restoring-divider subtractor cell: x - y with borrow, plus the
// restore mux that picks the difference or the untouched x bit.
module div_sub_cell #(
   parameter bit APPROX = 1'b0
) (
   input  logic x,
   input  logic y,
   input  logic bin,
   input  logic qs,
   output logic r_sub,
   output logic bout
);

   logic diff;
   logic unused_bin;

   // The approximate cell ignores the incoming borrow entirely
   assign diff       = APPROX ? y : (x ^ y ^ bin);
   assign bout       = APPROX ? (x & ~y) : ((~x & y) | (~(x ^ y) & bin));
   assign r_sub      = qs ? diff : x;
   assign unused_bin = bin;

endmodule

// File: rtl/seq_approx_array_divider.sv
// Iterative restoring divider, 2*WIDTH-bit dividend by WIDTH-bit divisor,
// evaluating UNROLL array rows per clock. Rows below APPROX_ROWS use the
// approximate subtractor in columns below APPROX_COLS.
// Optional feature macro: DIV_ZERO_DETECT_EN (early divide-by-zero result).
//
// Handshake: operands transfer on a rising edge where in_valid && in_ready;
// in_ready is high only in IDLE. The result transfers on a rising edge where
// out_valid && out_ready; q, r and div_by_zero hold still while out_valid is
// high and out_ready is low. Operands are only sampled on the accept edge.
module seq_approx_array_divider
   import div_approx_pkg::*;
#(
   parameter int WIDTH       = 8,  // >= 2
   parameter int APPROX_ROWS = 2,  // <= WIDTH, 0 gives a fully exact divider
   parameter int APPROX_COLS = 8,  // <= WIDTH
   parameter int UNROLL      = 1   // must divide WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] n,
   input  logic [WIDTH-1:0]   d,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   r,
   output logic               div_by_zero
);

   localparam int KW = $clog2(WIDTH);

   state_e             state, state_next;
   logic [KW-1:0]      k_reg, k_next;      // index of the next row to evaluate
   logic [WIDTH:0]     p_reg, p_next;      // partial remainder incl. extension bit
   logic [WIDTH-1:0]   n_low, n_low_next;  // dividend bits shifted into P later
   logic [WIDTH-1:0]   d_reg, d_next;
   logic [WIDTH-1:0]   q_reg, q_next;
   logic [WIDTH-1:0]   r_reg, r_next;
   logic [UNROLL-1:0]  row_qs;
   logic [WIDTH:0]     last_p;
   logic [WIDTH-1:0]   last_r;

   // Unrolled array rows: row u evaluates quotient bit k_reg - u
   for (genvar u = 0; u < UNROLL; u++) begin : g_row
      logic [KW-1:0]    k_u;
      logic [WIDTH:0]   p_in;
      logic [WIDTH:0]   p_out;
      logic [WIDTH-1:0] r_k;
      logic             qs;
      logic             n_bit;

      assign k_u = k_reg - KW'(u);

      if (u == 0) begin : g_first
         assign p_in = p_reg;
      end else begin : g_chain
         assign p_in = g_row[u-1].p_out;
      end

      for (genvar c = 0; c < WIDTH; c++) begin : g_col
         logic bin, bout, bout_e, bout_a, r_e, r_a, use_approx;

         if (c == 0) begin : g_bin0
            assign bin = 1'b0;
         end else begin : g_binc
            assign bin = g_col[c-1].bout;
         end

         div_sub_cell #(.APPROX(1'b0)) u_exact (
            .x(p_in[c]), .y(d_reg[c]), .bin(bin), .qs(qs),
            .r_sub(r_e), .bout(bout_e)
         );
         div_sub_cell #(.APPROX(1'b1)) u_approx (
            .x(p_in[c]), .y(d_reg[c]), .bin(bin), .qs(qs),
            .r_sub(r_a), .bout(bout_a)
         );

         // Row index is only known at run time, so the cell kind is muxed
         assign use_approx = (cell_is_approx(int'(k_u), c, APPROX_ROWS, APPROX_COLS)
                              == CELL_APPROX);
         assign bout       = use_approx ? bout_a : bout_e;
         assign r_k[c]     = use_approx ? r_a : r_e;
      end

      // A set extension bit means the subtraction cannot go negative
      assign qs        = p_in[WIDTH] | ~g_col[WIDTH-1].bout;
      assign n_bit     = (k_u != '0) ? n_low[k_u - KW'(1)] : 1'b0;
      assign p_out     = {r_k, n_bit};
      assign row_qs[u] = qs;
   end

   assign last_p = g_row[UNROLL-1].p_out;
   assign last_r = g_row[UNROLL-1].r_k;

`ifdef DIV_ZERO_DETECT_EN
   logic dz_reg, dz_next;
`else
   logic unused_n_msb;
   assign unused_n_msb = n_low[WIDTH-1];
`endif

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         k_reg <= '0;
         p_reg <= '0;
         n_low <= '0;
         d_reg <= '0;
         q_reg <= '0;
         r_reg <= '0;
`ifdef DIV_ZERO_DETECT_EN
         dz_reg <= 1'b0;
`endif
      end else begin
         state <= state_next;
         k_reg <= k_next;
         p_reg <= p_next;
         n_low <= n_low_next;
         d_reg <= d_next;
         q_reg <= q_next;
         r_reg <= r_next;
`ifdef DIV_ZERO_DETECT_EN
         dz_reg <= dz_next;
`endif
      end
   end

   // Next-state, datapath update and handshake outputs
   always_comb begin
      state_next = state;
      k_next     = k_reg;
      p_next     = p_reg;
      n_low_next = n_low;
      d_next     = d_reg;
      q_next     = q_reg;
      r_next     = r_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
      dz_next    = dz_reg;
`endif
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = BUSY;
               k_next     = KW'(WIDTH - 1);
               p_next     = n[2*WIDTH-1:WIDTH-1];
               n_low_next = n[WIDTH-1:0];
               d_next     = d;
               q_next     = '0;
               r_next     = '0;
`ifdef DIV_ZERO_DETECT_EN
               dz_next    = (d == '0);
`endif
            end
         end
         BUSY: begin
`ifdef DIV_ZERO_DETECT_EN
            if (dz_reg) begin
               state_next = DONE;
               q_next     = '1;
               r_next     = n_low;
            end else
`endif
            begin
               for (int u = 0; u < UNROLL; u++) begin
                  q_next[k_reg - KW'(u)] = row_qs[u];
               end
               p_next = last_p;
               k_next = k_reg - KW'(UNROLL);
               if (k_reg == KW'(UNROLL - 1)) begin
                  state_next = DONE;
                  r_next     = last_r;
               end
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign q = q_reg;
   assign r = r_reg;
`ifdef DIV_ZERO_DETECT_EN
   assign div_by_zero = dz_reg;
`else
   assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_approx_array_divider.sv
// Directed bench for seq_approx_array_divider: a default (approximate)
// instance, a fully exact instance and an exact UNROLL=2 instance.
module tb_seq_approx_array_divider;

   logic        clk;
   logic        rst;
   logic [2:0]  in_valid, in_ready, out_valid, out_ready, dz;
   logic [15:0] n_v [3];
   logic [7:0]  d_v [3];
   logic [7:0]  q_v [3];
   logic [7:0]  r_v [3];

   int checks = 0;
   int errors = 0;

   seq_approx_array_divider u_dut_def (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .n(n_v[0]), .d(d_v[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .q(q_v[0]), .r(r_v[0]), .div_by_zero(dz[0])
   );

   seq_approx_array_divider #(.APPROX_ROWS(0)) u_dut_exact (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .n(n_v[1]), .d(d_v[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .q(q_v[1]), .r(r_v[1]), .div_by_zero(dz[1])
   );

   seq_approx_array_divider #(.APPROX_ROWS(0), .UNROLL(2)) u_dut_u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .n(n_v[2]), .d(d_v[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .q(q_v[2]), .r(r_v[2]), .div_by_zero(dz[2])
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Row recurrence of the divider, cell by cell
   function automatic void model_div(input logic [15:0] nn, input logic [7:0] dd,
                                     input int ar, input int ac,
                                     output logic [7:0] qq, output logic [7:0] rr);
      logic [8:0] p;
      logic [7:0] x, diff;
      logic       b, bo;
      p = nn[15:7];
      qq = '0;
      rr = '0;
      diff = '0;
      for (int k = 7; k >= 0; k--) begin
         x = p[7:0];
         b = 1'b0;
         for (int c = 0; c < 8; c++) begin
            if (k < ar && c < ac) begin
               diff[c] = dd[c];
               bo = x[c] & ~dd[c];
            end else begin
               diff[c] = x[c] ^ dd[c] ^ b;
               bo = (~x[c] & dd[c]) | (~(x[c] ^ dd[c]) & b);
            end
            b = bo;
         end
         qq[k] = p[8] | ~b;
         if (qq[k]) x = diff;
         if (k > 0) p = {x, nn[k-1]};
         else rr = x;
      end
   endfunction

   // Present operands for one accept edge, then scramble them
   task automatic start_op(input int i, input logic [15:0] nn, input logic [7:0] dd);
      @(posedge clk); #1;
      n_v[i] = nn;
      d_v[i] = dd;
      in_valid[i] = 1'b1;
      @(posedge clk); #1;
      in_valid[i] = 1'b0;
      n_v[i] = 16'($urandom);
      d_v[i] = 8'($urandom);
   endtask

   // Count cycles from the accept edge until out_valid, bounded
   task automatic wait_done(input int i, output int cyc);
      cyc = 0;
      while (!out_valid[i] && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic finish_op(input int i);
      out_ready[i] = 1'b1;
      @(posedge clk); #1;
      out_ready[i] = 1'b0;
   endtask

   task automatic do_op(input int i, input logic [15:0] nn, input logic [7:0] dd,
                        input logic [7:0] eq, input logic [7:0] er, input logic edz,
                        input int elat, input string tag);
      int cyc;
      start_op(i, nn, dd);
      wait_done(i, cyc);
      check({tag, ".latency"}, 32'(cyc), 32'(elat));
      check({tag, ".q"}, 32'(q_v[i]), 32'(eq));
      check({tag, ".r"}, 32'(r_v[i]), 32'(er));
      check({tag, ".dz"}, 32'(dz[i]), 32'(edz));
      finish_op(i);
      check({tag, ".idle"}, 32'({out_valid[i], in_ready[i]}), 32'(2'b01));
   endtask

   initial begin
      logic [15:0] nn;
      logic [7:0]  dd, eq, er, hq, hr;
      int          cyc;

      rst = 1'b1;
      in_valid = '0;
      out_ready = '0;
      for (int i = 0; i < 3; i++) begin
         n_v[i] = '0;
         d_v[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;

      // Reset state of every instance
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset%0d.in_ready", i), 32'(in_ready[i]), 32'd1);
         check($sformatf("reset%0d.out_valid", i), 32'(out_valid[i]), 32'd0);
         check($sformatf("reset%0d.q", i), 32'(q_v[i]), 32'd0);
         check($sformatf("reset%0d.r", i), 32'(r_v[i]), 32'd0);
         check($sformatf("reset%0d.dz", i), 32'(dz[i]), 32'd0);
      end
      rst = 1'b0;

      // Exact divider, hand-computed quotients
      do_op(1, 16'd200, 8'd7, 8'd28, 8'd4, 1'b0, 8, "exact_200_7");
      do_op(1, 16'h1234, 8'h55, 8'h36, 8'h46, 1'b0, 8, "exact_1234_55");

      // Approximate rows deviate: 0/1 gives q=3, r=1
      do_op(0, 16'd0, 8'd1, 8'h03, 8'h01, 1'b0, 8, "approx_0_1");

      // UNROLL=2: overflow case and a normal one, both in 4 cycles
      do_op(2, 16'hFF00, 8'hFF, 8'hFF, 8'hFF, 1'b0, 4, "u2_overflow");
      do_op(2, 16'd12345, 8'd200, 8'd61, 8'd145, 1'b0, 4, "u2_12345_200");

      // Default config against the row-recurrence model
      for (int t = 0; t < 6; t++) begin
         dd = 8'($urandom_range(1, 255));
         nn = 16'($urandom_range(0, int'(dd) * 256 - 1));
         model_div(nn, dd, 2, 8, eq, er);
         do_op(0, nn, dd, eq, er, 1'b0, 8, $sformatf("approx_rand%0d", t));
      end

      // Exact instance against integer division
      for (int t = 0; t < 4; t++) begin
         dd = 8'($urandom_range(1, 255));
         nn = 16'($urandom_range(0, int'(dd) * 256 - 1));
         do_op(1, nn, dd, 8'(nn / 16'(dd)), 8'(nn % 16'(dd)), 1'b0, 8,
               $sformatf("exact_rand%0d", t));
      end

      // Back-pressure: result held for 5 cycles, new operands ignored
      dd = 8'($urandom_range(1, 255));
      nn = 16'($urandom_range(0, int'(dd) * 256 - 1));
      model_div(nn, dd, 2, 8, hq, hr);
      start_op(0, nn, dd);
      wait_done(0, cyc);
      check("hold.latency", 32'(cyc), 32'd8);
      n_v[0] = 16'h0101;
      d_v[0] = 8'h03;
      in_valid[0] = 1'b1;
      for (int t = 0; t < 5; t++) begin
         check($sformatf("hold%0d.q", t), 32'(q_v[0]), 32'(hq));
         check($sformatf("hold%0d.r", t), 32'(r_v[0]), 32'(hr));
         check($sformatf("hold%0d.ready_valid", t), 32'({in_ready[0], out_valid[0]}), 32'(2'b01));
         @(posedge clk); #1;
      end
      in_valid[0] = 1'b0;
      finish_op(0);
      check("hold.idle", 32'({out_valid[0], in_ready[0]}), 32'(2'b01));

      // Reset on the third BUSY cycle discards the operation
      start_op(1, 16'd500, 8'd9);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst.in_ready", 32'(in_ready[1]), 32'd1);
      check("midrst.out_valid", 32'(out_valid[1]), 32'd0);
      check("midrst.q", 32'(q_v[1]), 32'd0);
      do_op(1, 16'd1000, 8'd13, 8'd76, 8'd12, 1'b0, 8, "after_rst");

      // Divide by zero
`ifdef DIV_ZERO_DETECT_EN
      do_op(0, 16'h1234, 8'h00, 8'hFF, 8'h34, 1'b1, 1, "div_zero");
`else
      model_div(16'h1234, 8'h00, 2, 8, eq, er);
      do_op(0, 16'h1234, 8'h00, eq, er, 1'b0, 8, "div_zero");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
